// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// It captures decoded operands, register addresses and control bits from ID.
// A load-use dependency inserts one bubble and freezes PC and IF/ID. A branch
// flush squashes the instruction entering EX. An external hold freezes the
// whole stage. Two saturating counters track bubbles and flushes.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Flush_i,
  input  logic              Hold_i,
  input  logic [4:0]        IFID_Rs_addr,
  input  logic [4:0]        IFID_Rt_addr,
  input  logic [4:0]        IFID_Rd_addr,
  input  logic [DATA_W-1:0] RS_data,
  input  logic [DATA_W-1:0] RT_data,
  input  logic [DATA_W-1:0] Imm,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              ALUSrc,
  input  logic              RegDst,
  input  logic [2:0]        ALUOp,
  output logic [4:0]        ID_EX_Rs_addr,
  output logic [4:0]        ID_EX_Rt_addr,
  output logic [4:0]        ID_EX_Rd_addr,
  output logic [DATA_W-1:0] ID_EX_RS_data,
  output logic [DATA_W-1:0] ID_EX_RT_data,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_RegDst,
  output logic [2:0]        ID_EX_ALUOp,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              Hazard_o,
  output logic [CNT_W-1:0]  Bubble_cnt,
  output logic [CNT_W-1:0]  Flush_cnt
);

  // All pipeline fields are grouped so that a bubble is one assignment.
  typedef struct packed {
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [2:0]        alu_op;
  } id_ex_t;

  localparam id_ex_t      BUBBLE  = '0;
  localparam [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  id_ex_t id_in;
  id_ex_t id_ex_q;
  logic   load_use;

  assign id_in = '{
    rs_addr:    IFID_Rs_addr,
    rt_addr:    IFID_Rt_addr,
    rd_addr:    IFID_Rd_addr,
    rs_data:    RS_data,
    rt_data:    RT_data,
    imm:        Imm,
    reg_write:  RegWrite,
    mem_read:   MemRead,
    mem_write:  MemWrite,
    mem_to_reg: MemtoReg,
    alu_src:    ALUSrc,
    reg_dst:    RegDst,
    alu_op:     ALUOp
  };

  // Load in EX whose destination ($0 excluded) is read by the instruction in ID.
  assign load_use = id_ex_q.mem_read && (id_ex_q.rt_addr != 5'd0) &&
                    ((id_ex_q.rt_addr == IFID_Rs_addr) ||
                     (id_ex_q.rt_addr == IFID_Rt_addr));

  // Front-end enables; a flush always lets the redirect through.
  assign Hazard_o   = load_use;
  assign PC_Write   = Flush_i || !(Hold_i || load_use);
  assign IFID_Write = PC_Write;

  // Pipeline register and performance counters, priority reset > flush > hold > stall.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge
    // values, so the hazard term read here is the one seen by the front end.
    if (!rst_i) begin
      id_ex_q    <= BUBBLE;
      Bubble_cnt <= '0;
      Flush_cnt  <= '0;
    end else if (Flush_i) begin
      id_ex_q <= BUBBLE;
      if (Flush_cnt != CNT_MAX) Flush_cnt <= Flush_cnt + 1'b1;
    end else if (Hold_i) begin
      id_ex_q <= id_ex_q;
    end else if (load_use) begin
      id_ex_q <= BUBBLE;
      if (Bubble_cnt != CNT_MAX) Bubble_cnt <= Bubble_cnt + 1'b1;
    end else begin
      id_ex_q <= id_in;
    end
  end

  assign ID_EX_Rs_addr  = id_ex_q.rs_addr;
  assign ID_EX_Rt_addr  = id_ex_q.rt_addr;
  assign ID_EX_Rd_addr  = id_ex_q.rd_addr;
  assign ID_EX_RS_data  = id_ex_q.rs_data;
  assign ID_EX_RT_data  = id_ex_q.rt_data;
  assign ID_EX_Imm      = id_ex_q.imm;
  assign ID_EX_RegWrite = id_ex_q.reg_write;
  assign ID_EX_MemRead  = id_ex_q.mem_read;
  assign ID_EX_MemWrite = id_ex_q.mem_write;
  assign ID_EX_MemtoReg = id_ex_q.mem_to_reg;
  assign ID_EX_ALUSrc   = id_ex_q.alu_src;
  assign ID_EX_RegDst   = id_ex_q.reg_dst;
  assign ID_EX_ALUOp    = id_ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver applies directed vectors and
// queues hand-computed expectations; the monitor pops and compares each cycle.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  // ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst}
  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [5:0]  ctrl;
    logic [2:0]  aluop;
  } fld_t;

  typedef struct {
    logic       chk_comb;
    logic       haz;
    logic       pcw;
    fld_t       regs;
    logic [3:0] bc;
    logic [3:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, hold;
  fld_t din;
  fld_t act;

  logic [4:0]        id_ex_rs, id_ex_rt, id_ex_rd;
  logic [DATA_W-1:0] id_ex_rsd, id_ex_rtd, id_ex_imm;
  logic              o_rw, o_mr, o_mw, o_m2r, o_as, o_rd;
  logic [2:0]        o_aluop;
  logic              pc_write, ifid_write, hazard;
  logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .Flush_i(flush), .Hold_i(hold),
    .IFID_Rs_addr(din.rs), .IFID_Rt_addr(din.rt), .IFID_Rd_addr(din.rd),
    .RS_data(din.rsd), .RT_data(din.rtd), .Imm(din.imm),
    .RegWrite(din.ctrl[5]), .MemRead(din.ctrl[4]), .MemWrite(din.ctrl[3]),
    .MemtoReg(din.ctrl[2]), .ALUSrc(din.ctrl[1]), .RegDst(din.ctrl[0]),
    .ALUOp(din.aluop),
    .ID_EX_Rs_addr(id_ex_rs), .ID_EX_Rt_addr(id_ex_rt), .ID_EX_Rd_addr(id_ex_rd),
    .ID_EX_RS_data(id_ex_rsd), .ID_EX_RT_data(id_ex_rtd), .ID_EX_Imm(id_ex_imm),
    .ID_EX_RegWrite(o_rw), .ID_EX_MemRead(o_mr), .ID_EX_MemWrite(o_mw),
    .ID_EX_MemtoReg(o_m2r), .ID_EX_ALUSrc(o_as), .ID_EX_RegDst(o_rd),
    .ID_EX_ALUOp(o_aluop),
    .PC_Write(pc_write), .IFID_Write(ifid_write), .Hazard_o(hazard),
    .Bubble_cnt(bubble_cnt), .Flush_cnt(flush_cnt)
  );

  assign act = '{rs: id_ex_rs, rt: id_ex_rt, rd: id_ex_rd,
                 rsd: id_ex_rsd, rtd: id_ex_rtd, imm: id_ex_imm,
                 ctrl: {o_rw, o_mr, o_mw, o_m2r, o_as, o_rd}, aluop: o_aluop};

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  // Vectors
  localparam fld_t BUB  = '0;
  localparam fld_t JUNK = '{5'd31, 5'd30, 5'd29, 32'hdead_beef, 32'hcafe_f00d,
                            32'h1234_5678, 6'h3f, 3'd7};
  localparam fld_t ADD  = '{5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0, 6'b100001, 3'd2};
  localparam fld_t LW2  = '{5'd1, 5'd2, 5'd0, 32'h100, 32'h55, 32'h4, 6'b110110, 3'd0};
  localparam fld_t LW0  = '{5'd1, 5'd0, 5'd0, 32'h100, 32'h55, 32'h8, 6'b110110, 3'd0};
  localparam fld_t ADDD = '{5'd2, 5'd4, 5'd5, 32'h30, 32'h40, 32'h0, 6'b100001, 3'd2};
  localparam fld_t ADZ  = '{5'd0, 5'd4, 5'd5, 32'h0, 32'h40, 32'h0, 6'b100001, 3'd2};
  localparam fld_t XRT  = '{5'd7, 5'd2, 5'd9, 32'h70, 32'h2, 32'h0, 6'b100001, 3'd6};

  // Drive one cycle of stimulus and queue its expected response.
  task automatic step(input fld_t in, input logic r, input logic f, input logic h,
                      input logic chk, input logic e_haz, input logic e_pcw,
                      input fld_t e_regs, input int e_bc, input int e_fc);
    exp_t e;
    @(negedge clk);
    din = in; rst = r; flush = f; hold = h;
    e.chk_comb = chk; e.haz = e_haz; e.pcw = e_pcw; e.regs = e_regs;
    e.bc = 4'(e_bc); e.fc = 4'(e_fc);
    sb.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_comb) begin
          check("hazard", 128'(hazard), 128'(e.haz));
          check("pc_write", 128'(pc_write), 128'(e.pcw));
          check("ifid_write", 128'(ifid_write), 128'(e.pcw));
        end
        @(posedge clk);
        #1;
        check("id_ex_regs", 128'(act), 128'(e.regs));
        check("bubble_cnt", 128'(bubble_cnt), 128'(e.bc));
        check("flush_cnt", 128'(flush_cnt), 128'(e.fc));
      end
    end
  end

  initial begin : driver
    din = JUNK; rst = 1'b0; flush = 1'b0; hold = 1'b0;
    // Reset with non-zero operands
    step(JUNK, 0, 0, 0, 0, 0, 0, BUB, 0, 0);
    step(JUNK, 0, 0, 0, 1, 0, 1, BUB, 0, 0);
    // Pass-through
    step(ADD,  1, 0, 0, 1, 0, 1, ADD, 0, 0);
    // Load-use on Rs: one bubble, then the add
    step(LW2,  1, 0, 0, 1, 0, 1, LW2, 0, 0);
    step(ADDD, 1, 0, 0, 1, 1, 0, BUB, 1, 0);
    step(ADDD, 1, 0, 0, 1, 0, 1, ADDD, 1, 0);
    // Load to $0: no stall
    step(LW0,  1, 0, 0, 1, 0, 1, LW0, 1, 0);
    step(ADZ,  1, 0, 0, 1, 0, 1, ADZ, 1, 0);
    // Flush during hazard
    step(LW2,  1, 0, 0, 1, 0, 1, LW2, 1, 0);
    step(ADDD, 1, 1, 0, 1, 1, 1, BUB, 1, 1);
    step(ADDD, 1, 0, 0, 1, 0, 1, ADDD, 1, 1);
    // Hold for 3 cycles with the load in EX, then a single bubble
    step(LW2,  1, 0, 0, 1, 0, 1, LW2, 1, 1);
    for (int i = 0; i < 3; i++)
      step(ADDD, 1, 0, 1, 1, 1, 0, LW2, 1, 1);
    step(ADDD, 1, 0, 0, 1, 1, 0, BUB, 2, 1);
    step(ADDD, 1, 0, 0, 1, 0, 1, ADDD, 2, 1);
    // Hold alone, then flush with hold
    step(ADD,  1, 0, 1, 1, 0, 0, ADDD, 2, 1);
    step(ADD,  1, 1, 1, 1, 0, 1, BUB, 2, 2);
    // Load-use through Rt
    step(LW2,  1, 0, 0, 1, 0, 1, LW2, 2, 2);
    step(XRT,  1, 0, 0, 1, 1, 0, BUB, 3, 2);
    step(XRT,  1, 0, 0, 1, 0, 1, XRT, 3, 2);
    // Reset mid-stall
    step(LW2,  1, 0, 0, 1, 0, 1, LW2, 3, 2);
    step(ADDD, 0, 0, 0, 1, 1, 0, BUB, 0, 0);
    step(ADDD, 1, 0, 0, 1, 0, 1, ADDD, 0, 0);
    // Flush counter saturation
    for (int i = 0; i < 20; i++)
      step(ADD, 1, 1, 0, 1, 0, 1, BUB, 0, (i + 1 > 15) ? 15 : i + 1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
